bloco_controle: RTL
===================

# bloco_controle

Control block (BC) for the accumulate-by-count datapath (BO). It sequences the BO strobes `rac`, `cac`, `set` and `dec` to add `valor` into the accumulator once per counter step until BO reports `zero0`. It provides a start/done handshake and a latched result with an overflow flag. It sits directly upstream of BO: it drives BO's control inputs and consumes BO's `soma` and `zero0`.

## Interface
- `MAX_ITER`, default 16: watchdog limit on SOMA visits per run.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  run request; level-sampled in IDLE only.
- `zero`  in  1  BO `zero0`.
- `soma`  in  8  BO accumulator value.
- `valor`  in  8  addend, the same bus that feeds BO; used only for overflow detection.
- `rac`  out  1  clear accumulator.
- `cac`  out  1  accumulator captures `soma+valor`.
- `set`  out  1  preset BO counter.
- `dec`  out  1  decrement BO counter.
- `ocupado`  out  1  high in every state except IDLE.
- `pronto`  out  1  one-cycle done pulse.
- `resultado`  out  8  result register.
- `estouro`  out  1  sticky overflow of the current or last run.
- `erro`  out  1  watchdog tripped on the current or last run.

## Operation
- Moore FSM with states IDLE, INIT, ESPERA, TESTA, SOMA, FIM.
- IDLE: all strobes are 0. `start=1` moves to INIT. Otherwise stay in IDLE.
- INIT: `rac=1`, `set=1`. Clears `estouro`, `erro` and the iteration count. Next state is ESPERA.
- ESPERA: no strobes. Covers the one-cycle registered delay of BO `zero0`. Next state is TESTA.
- TESTA: no strobes.
  - `zero=1` moves to FIM.
  - Iteration count equal to `MAX_ITER` sets `erro` and moves to FIM.
  - Otherwise move to SOMA.
- SOMA: `cac=1`, `dec=1`.
  - Increments the iteration count.
  - Sets `estouro` if `{1'b0,soma}+{1'b0,valor} > 255`. The check uses the pre-capture `soma`.
  - Next state is ESPERA.
- FIM: `pronto=1`, `resultado <= soma`. Next state is IDLE.
- Strobes are decoded from state only, never from inputs.
- `start` is ignored outside IDLE.
- If `start` is held high, a new run begins on the cycle after FIM returns to IDLE.
- Accumulator arithmetic is modulo 256. `resultado` keeps the wrapped value.
- Counter preset of 0: `zero` is seen at the first TESTA, so the run has no SOMA and `resultado=0`.

## Timing
- Reset (`rst=0`, async) forces:
  - state = IDLE;
  - all strobes, `ocupado` and `pronto` = 0;
  - `resultado` = 8'h00;
  - `estouro`, `erro` and the iteration count = 0.
- A reset during a run aborts immediately, with no `pronto`.
- Latency from the edge that samples `start` in IDLE to the `pronto` cycle, for counter preset N: 3 + 3N cycles. `pronto` is visible in cycle 4 + 3N counting IDLE as cycle 0.
- `resultado`, `estouro` and `erro` are valid from the `pronto` cycle and hold until the next INIT (or reset).
- `ocupado` rises the cycle after `start` is sampled and falls when IDLE is re-entered.
- The watchdog trip gives the same FIM/`pronto` timing with `erro=1`.

## Structure
- Shared header `bc_defs.vh` holds:
  - the state encoding localparams (3-bit binary, IDLE=0);
  - the default `MAX_ITER`.
- Sub-module `contador_guarda`: 5-bit iteration counter with `clr`, `inc` and a `limite` compare output, parameterised by `MAX_ITER`.
- The FSM and the result/flag registers stay in `bloco_controle`.
- The top-level system instantiates `bloco_controle` and BO side by side. `valor` is shared between them.

## Test plan
- Bench BO model preset to 3, `valor=7`, `start` pulsed once.
  - Required: `resultado=21`, `estouro=0`, `erro=0`.
  - `pronto` appears exactly 12 cycles after `start` is sampled.
  - Exactly 3 `cac`/`dec` pulses.
- Preset 3, `valor=100`.
  - Required: `resultado=44`, `estouro=1` (set on the third SOMA).
  - A following run with `valor=1` clears `estouro`.
- Preset 0, `valor=9`.
  - Required: no SOMA and `resultado=0`.
  - `pronto` 3 cycles after `start`.
- BO model whose `zero` never asserts, `MAX_ITER=16`.
  - Required: exactly 16 SOMA cycles, then `erro=1` and a `pronto` pulse.
- `rst` asserted during the second SOMA.
  - Required: same cycle, all outputs 0 and `resultado=0`.
  - No `pronto`. A new run after release completes normally.
- `start` held high for 3 runs.
  - Required: back-to-back runs, one IDLE cycle between each `pronto` and the next INIT.
  - `start` toggling mid-run has no effect.

Source files
------------

// File: rtl/bloco_controle_pkg.sv
// -----------------------------------------------------------------------------
// bloco_controle_pkg
// Shared definitions for the accumulate-by-count control block (BC):
//   - estado_t     : FSM state encoding (3-bit binary, IDLE = 0)
//   - MAX_ITER_DEF : default watchdog limit on SOMA visits per run
//   - CNT_W        : width of the iteration counter
//   - soma_estoura : 8-bit unsigned add carry-out test used for overflow
// -----------------------------------------------------------------------------
package bloco_controle_pkg;

    localparam int MAX_ITER_DEF = 16;
    localparam int CNT_W        = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        ESPERA = 3'd2,
        TESTA  = 3'd3,
        SOMA   = 3'd4,
        FIM    = 3'd5
    } estado_t;

    // True when a + b does not fit in 8 bits.
    function automatic logic soma_estoura(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8];
    endfunction

endpackage

// File: rtl/bloco_controle_if.sv
// -----------------------------------------------------------------------------
// bloco_controle_if
// Bundles the BC start/done handshake, result flags and the BO control link.
// Handshake: start is a level request sampled only while BC is idle
// (ocupado = 0); the run is done when pronto pulses for one cycle, and
// resultado/estouro/erro are valid from that cycle until the next run starts.
//   start     : run request (to BC)
//   zero      : BO zero0, already registered inside BO (to BC)
//   soma      : BO accumulator value (to BC)
//   valor     : addend shared with BO, overflow detection only (to BC)
//   rac/cac/set/dec : BO strobes (from BC)
//   ocupado, pronto, resultado, estouro, erro : status (from BC)
//   estado    : current FSM state, debug visibility (from BC)
// Modports: slave = the control block, master = its environment.
// -----------------------------------------------------------------------------
interface bloco_controle_if;
    import bloco_controle_pkg::*;

    logic       start;
    logic       zero;
    logic [7:0] soma;
    logic [7:0] valor;
    logic       rac;
    logic       cac;
    logic       set;
    logic       dec;
    logic       ocupado;
    logic       pronto;
    logic [7:0] resultado;
    logic       estouro;
    logic       erro;
    estado_t    estado;

    modport slave (
        input  start, zero, soma, valor,
        output rac, cac, set, dec, ocupado, pronto, resultado, estouro, erro, estado
    );

    modport master (
        output start, zero, soma, valor,
        input  rac, cac, set, dec, ocupado, pronto, resultado, estouro, erro, estado
    );

endinterface

// File: rtl/bloco_controle_contador_guarda.sv
// -----------------------------------------------------------------------------
// contador_guarda
// Watchdog iteration counter for the control block.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   clr_i    : clear count to 0 (has priority over inc_i)
//   inc_i    : increment count
//   limite_o : count equals MAX_ITER
// -----------------------------------------------------------------------------
module contador_guarda
    import bloco_controle_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic limite_o
);

    localparam logic [CNT_W-1:0] LIMITE = CNT_W'(MAX_ITER);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limite_o = (cnt_q == LIMITE);

endmodule

// File: rtl/bloco_controle.sv
// -----------------------------------------------------------------------------
// bloco_controle
// Control block for the accumulate-by-count datapath. Sequences BO strobes so
// that valor is added into the accumulator once per counter step until BO
// reports zero0, then latches the result with overflow and watchdog flags.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : bloco_controle_if.slave (handshake, BO link, status, debug state)
// Strobes and status are Moore outputs decoded from the state register only.
// -----------------------------------------------------------------------------
module bloco_controle
    import bloco_controle_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    bloco_controle_if.slave       bus
);

    estado_t    estado_q, estado_d;
    logic [7:0] resultado_q, resultado_d;
    logic       estouro_q, estouro_d;
    logic       erro_q, erro_d;
    logic       limite;

    contador_guarda #(
        .MAX_ITER (MAX_ITER)
    ) u_guarda (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (estado_q == INIT),
        .inc_i    (estado_q == SOMA),
        .limite_o (limite)
    );

    always_comb begin
        estado_d    = estado_q;
        resultado_d = resultado_q;
        estouro_d   = estouro_q;
        erro_d      = erro_q;
        case (estado_q)
            IDLE: begin
                if (bus.start) estado_d = INIT;
            end
            INIT: begin
                estouro_d = 1'b0;
                erro_d    = 1'b0;
                estado_d  = ESPERA;
            end
            ESPERA: begin
                estado_d = TESTA;
            end
            TESTA: begin
                // The result is captured on the way into FIM so it is already
                // valid during the pronto cycle; soma is stable here because
                // no cac is issued in TESTA.
                if (bus.zero) begin
                    resultado_d = bus.soma;
                    estado_d    = FIM;
                end else if (limite) begin
                    resultado_d = bus.soma;
                    erro_d      = 1'b1;
                    estado_d    = FIM;
                end else begin
                    estado_d = SOMA;
                end
            end
            SOMA: begin
                // soma is the pre-capture accumulator value this cycle.
                if (soma_estoura(bus.soma, bus.valor)) estouro_d = 1'b1;
                estado_d = ESPERA;
            end
            FIM: begin
                estado_d = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q    <= IDLE;
            resultado_q <= 8'h00;
            estouro_q   <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            resultado_q <= resultado_d;
            estouro_q   <= estouro_d;
            erro_q      <= erro_d;
        end
    end

    assign bus.rac       = (estado_q == INIT);
    assign bus.set       = (estado_q == INIT);
    assign bus.cac       = (estado_q == SOMA);
    assign bus.dec       = (estado_q == SOMA);
    assign bus.ocupado   = (estado_q != IDLE);
    assign bus.pronto    = (estado_q == FIM);
    assign bus.resultado = resultado_q;
    assign bus.estouro   = estouro_q;
    assign bus.erro      = erro_q;
    assign bus.estado    = estado_q;

endmodule
